pu_array_sequencer: RTL and testbench
=====================================

# pu_array_sequencer

Sequencer for an N×N systolic array of PU multiply-accumulate cells. It takes one start command with an inner dimension k_len and runs the tile in order:
- clears the PU accumulators;
- reads operand rows from the A/B buffers;
- drives per-lane skewed valids into the array edge;
- steps a row-drain of results.

It sits between the top-level TPU command logic and the PU array plus its operand buffers.

## Interface
- DATA_WIDTH, 8: operand/result width of the PU array; carried for package consistency, no datapath here.
- N, 4: array dimension (lanes); N ≥ 2.
- K_MAX, 16: maximum inner dimension; power of two.
- AW, $clog2(K_MAX): buffer read-address width.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high; returns block to IDLE.
- start  in  1  command strobe, sampled only in IDLE.
- k_len  in  AW+1  inner dimension for the command, sampled with start.
- hold  in  1  stall request, effective in FEED and DRAIN only.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at tile completion.
- err  out  1  one-cycle pulse when start is rejected.
- pu_clear  out  1  accumulator clear to all PUs (drives PU reset).
- pu_en  out  1  PU enable (drives PU en).
- rd_en  out  1  operand buffer read strobe.
- rd_addr  out  AW  operand buffer row address.
- lane_valid  out  N  per-lane skewed operand-valid into the array edge.
- out_valid  out  1  result row valid.
- out_row  out  $clog2(N)  index of the result row being drained.

## Operation
FSM states: IDLE, CLEAR, FEED, DRAIN, DONE.
- **IDLE**
  - start=1 with k_len≥1 → latch k_eff = min(k_len, K_MAX) → CLEAR.
  - start=1 with k_len=0 → err=1 for one cycle, stay IDLE.
- **CLEAR**: exactly 1 cycle; pu_clear=1; hold ignored; → FEED.
- **FEED**: feed counter c runs 0 .. k_eff+N-1, i.e. k_eff+N active cycles.
  - pu_en=1.
  - rd_en=1 and rd_addr=c while c<k_eff.
  - lane_valid[i]=1 while i+1 ≤ c ≤ i+k_eff. The +1 covers the buffer's 1-cycle read latency; the +i is the systolic skew.
  - Last active cycle → DRAIN.
- **DRAIN**: row counter r runs 0..N-1; out_valid=1, out_row=r; pu_en=0. After r=N-1 → DONE.
- **DONE**: 1 cycle; done=1; hold ignored; → IDLE.
- **hold** in FEED or DRAIN:
  - freezes c and r;
  - forces pu_en, rd_en, lane_valid and out_valid to 0;
  - rd_addr and out_row keep their value.
  - Active cycles resume exactly where they stopped.
- **start while busy**, including the DONE cycle: ignored, no err.
- **k_len** changes after the start cycle have no effect.
- **reset** in any state:
  - next cycle is IDLE;
  - counters are 0 and k_eff is 0;
  - no done pulse.

## Timing
- Reset values: busy, done, err, pu_clear, pu_en, rd_en, out_valid = 0; rd_addr = 0; out_row = 0; lane_valid = 0.
- All outputs are registered and decoded from state and counters; no combinational path from inputs to outputs.
- Start sampled at edge 0, no hold:
  - CLEAR in cycle 1;
  - FEED in cycles 2 .. k_eff+N+1;
  - DRAIN for the next N cycles;
  - done in cycle k_eff+2N+2.
- Each hold cycle adds one cycle to this latency.
- busy rises the cycle after an accepted start and falls the cycle after done.
- A back-to-back start is accepted at the earliest in the first IDLE cycle after DONE.

## Structure
- Package tpu_ctrl_pkg holds:
  - state enum typedef seq_state_t {IDLE, CLEAR, FEED, DRAIN, DONE};
  - function clamp_k(k_len, K_MAX).
- Sub-module pu_skew_gen: inputs c, k_eff, active → output lane_valid[N-1:0]. Purely combinational decode, registered in the top.
- Top holds the FSM, counters c and r, the k_eff register and the output registers.

## Test plan
- N=4, start with k_len=3 at cycle 0 → pu_clear in cycle 1; rd_addr 0,1,2 in cycles 2–4; lane_valid[0] in cycles 3–5, lane_valid[3] in cycles 6–8; out_row 0..3 in cycles 9–12; done in cycle 13.
- k_len=0 → err pulse one cycle, busy stays 0. k_len=31 with K_MAX=16 → rd_addr counts 0..15, done in cycle 26.
- k_len=3, hold high for 2 cycles at FEED c=1, then 1 cycle in DRAIN at r=2 → outputs gated during each hold, sequence resumes unchanged, done in cycle 16.
- start pulsed during FEED and again in the DONE cycle → ignored, no err; a second start in the next IDLE cycle → CLEAR follows immediately.
- reset asserted in FEED c=2 → next cycle all outputs at reset values with no done pulse; a new start then runs a full, correct tile.

Source files
------------

// File: rtl/tpu_ctrl_pkg.sv
// tpu_ctrl_pkg
// Shared types and helpers for the TPU control slice.
//   seq_state_t : sequencer FSM states
//   clamp_k     : limits a requested inner dimension to the array maximum
package tpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } seq_state_t;

    function automatic int clamp_k(input int k_len, input int k_max);
        return (k_len > k_max) ? k_max : k_len;
    endfunction

endpackage

// File: rtl/pu_skew_gen.sv
// pu_skew_gen
// Combinational decode of the per-lane operand-valid skew at the array edge.
// Lane i sees valid data for k_eff cycles starting at c = i+1: one cycle of
// buffer read latency plus i cycles of systolic skew.
// Ports:
//   c          in  CW     feed counter
//   k_eff      in  AW+1   clamped inner dimension of the running tile
//   active     in  1      feed cycle is live (FEED and not stalled)
//   lane_valid out N      per-lane valid, registered by the caller
module pu_skew_gen #(
    parameter int N  = 4,
    parameter int AW = 4,
    parameter int CW = 6
) (
    input  logic [CW-1:0] c,
    input  logic [AW:0]   k_eff,
    input  logic          active,
    output logic [N-1:0]  lane_valid
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign lane_valid[i] = active
                            && (c >= CW'(i + 1))
                            && (c <= CW'(k_eff) + CW'(i));
    end

endmodule

// File: rtl/pu_array_sequencer.sv
// pu_array_sequencer
// Runs one tile on an N x N systolic PU array: clear accumulators, stream
// k_eff operand rows with per-lane skew, then drain N result rows.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   start, k_len      command strobe and inner dimension (sampled in IDLE)
//   hold              stall request, honoured in FEED and DRAIN
//   busy, done, err   status; done/err are one-cycle pulses
//   pu_clear, pu_en   PU accumulator clear and enable
//   rd_en, rd_addr    operand buffer read strobe and row address
//   lane_valid        per-lane skewed operand valid
//   out_valid,out_row result row drain strobe and row index
// All outputs are registered; they are decoded from the next state and
// next counter values so they line up with the state they describe.
module pu_array_sequencer
    import tpu_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4,
    parameter int K_MAX      = 16,
    parameter int AW         = $clog2(K_MAX)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [AW:0]          k_len,
    input  logic                 hold,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 pu_clear,
    output logic                 pu_en,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    output logic [N-1:0]         lane_valid,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_row
);

    localparam int RW = $clog2(N);
    // Feed counter reaches k_eff+N-1 at most; one spare bit keeps the
    // skew compare (i + k_eff) from wrapping.
    localparam int CW = $clog2(K_MAX + N) + 1;

    if (N < 2 || DATA_WIDTH < 1 || K_MAX != (1 << AW)) begin : g_bad_param
        $error("pu_array_sequencer: illegal parameter set");
    end

    seq_state_t    state, state_d;
    logic [CW-1:0] c, c_d;
    logic [RW-1:0] r, r_d;
    logic [AW:0]   k_eff, k_eff_d;
    logic          stall_d;
    logic          err_d;
    logic          feed_act;
    logic          rd_en_d;
    logic          out_valid_d;
    logic [N-1:0]  lane_d;
    logic [CW-1:0] c_last;

    assign c_last = CW'(k_eff) + CW'(N - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            c     <= '0;
            r     <= '0;
            k_eff <= '0;
        end else begin
            state <= state_d;
            c     <= c_d;
            r     <= r_d;
            k_eff <= k_eff_d;
        end
    end

    // A held cycle keeps the current position and only gates the strobes,
    // so the next unstalled cycle advances from the last executed step.
    always_comb begin
        state_d = state;
        c_d     = c;
        r_d     = r;
        k_eff_d = k_eff;
        stall_d = 1'b0;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (k_len != '0) begin
                        state_d = CLEAR;
                        k_eff_d = (AW + 1)'(clamp_k(int'(k_len), K_MAX));
                        c_d     = '0;
                        r_d     = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                state_d = FEED;
                c_d     = '0;
            end
            FEED: begin
                if (hold) begin
                    stall_d = 1'b1;
                end else if (c == c_last) begin
                    state_d = DRAIN;
                    r_d     = '0;
                end else begin
                    c_d = c + CW'(1);
                end
            end
            DRAIN: begin
                if (hold) begin
                    stall_d = 1'b1;
                end else if (r == RW'(N - 1)) begin
                    state_d = DONE;
                end else begin
                    r_d = r + RW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign feed_act    = (state_d == FEED) && !stall_d;
    assign rd_en_d     = feed_act && (c_d < CW'(k_eff_d));
    assign out_valid_d = (state_d == DRAIN) && !stall_d;

    pu_skew_gen #(
        .N  (N),
        .AW (AW),
        .CW (CW)
    ) u_skew (
        .c          (c_d),
        .k_eff      (k_eff_d),
        .active     (feed_act),
        .lane_valid (lane_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            pu_clear   <= 1'b0;
            pu_en      <= 1'b0;
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            lane_valid <= '0;
            out_valid  <= 1'b0;
            out_row    <= '0;
        end else begin
            busy       <= (state_d != IDLE);
            done       <= (state_d == DONE);
            err        <= err_d;
            pu_clear   <= (state_d == CLEAR);
            pu_en      <= feed_act;
            rd_en      <= rd_en_d;
            lane_valid <= lane_d;
            out_valid  <= out_valid_d;
            // Address and row index hold their last value when not strobed.
            if (rd_en_d) begin
                rd_addr <= c_d[AW-1:0];
            end
            if (out_valid_d) begin
                out_row <= r_d;
            end
        end
    end

endmodule

// File: tb/tb_pu_array_sequencer.sv
module tb_pu_array_sequencer;

    localparam int N     = 4;
    localparam int K_MAX = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   k_len;
    logic          hold;
    logic          busy, done, err, pu_clear, pu_en, rd_en, out_valid;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  lane_valid;
    logic [1:0]    out_row;

    int n_tests = 0;
    int n_fail  = 0;

    pu_array_sequencer #(
        .DATA_WIDTH (8),
        .N          (N),
        .K_MAX      (K_MAX),
        .AW         (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .k_len      (k_len),
        .hold       (hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .pu_clear   (pu_clear),
        .pu_en      (pu_en),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .lane_valid (lane_valid),
        .out_valid  (out_valid),
        .out_row    (out_row)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // After this returns, outputs show the cycle following the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_err"},   err, 0);
        chk({tag, "_clr"},   pu_clear, 0);
        chk({tag, "_pu_en"}, pu_en, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_addr"},  rd_addr, 0);
        chk({tag, "_lane"},  lane_valid, 0);
        chk({tag, "_ov"},    out_valid, 0);
        chk({tag, "_row"},   out_row, 0);
    endtask

    // Start at edge 0 with no hold; cycle t expectations follow the tile
    // timeline: CLEAR 1, FEED 2..ke+N+1, DRAIN N cycles, done at ke+2N+2.
    task automatic run_trace(input int kl, input int ke);
        int last;
        int ov0;
        logic [N-1:0] lv;
        last = ke + 2 * N + 2;
        ov0  = ke + N + 2;
        start = 1'b1;
        k_len = (AW + 1)'(kl);
        step();
        start = 1'b0;
        for (int t = 1; t <= last + 1; t++) begin
            lv = '0;
            for (int i = 0; i < N; i++) lv[i] = (t >= 3 + i) && (t <= ke + 2 + i);
            chk($sformatf("k%0d_busy_c%0d", kl, t), busy, int'(t <= last));
            chk($sformatf("k%0d_clr_c%0d", kl, t), pu_clear, int'(t == 1));
            chk($sformatf("k%0d_pu_en_c%0d", kl, t), pu_en, int'(t >= 2 && t <= ke + N + 1));
            chk($sformatf("k%0d_rd_en_c%0d", kl, t), rd_en, int'(t >= 2 && t <= ke + 1));
            if (t >= 2 && t <= ke + 1)
                chk($sformatf("k%0d_addr_c%0d", kl, t), rd_addr, t - 2);
            chk($sformatf("k%0d_lane_c%0d", kl, t), lane_valid, lv);
            chk($sformatf("k%0d_ov_c%0d", kl, t), out_valid, int'(t >= ov0 && t < ov0 + N));
            if (t >= ov0 && t < ov0 + N)
                chk($sformatf("k%0d_row_c%0d", kl, t), out_row, t - ov0);
            chk($sformatf("k%0d_done_c%0d", kl, t), done, int'(t == last));
            chk($sformatf("k%0d_err_c%0d", kl, t), err, 0);
            step();
        end
    endtask

    initial begin
        int e_lane, e_row, e_addr;

        reset = 1'b1;
        start = 1'b0;
        k_len = '0;
        hold  = 1'b0;
        step();
        step();
        chk_reset_vals("rst");
        reset = 1'b0;
        step();

        // Basic tile, k=3.
        run_trace(3, 3);

        // Rejected start.
        start = 1'b1;
        k_len = '0;
        step();
        start = 1'b0;
        chk("k0_err", err, 1);
        chk("k0_busy", busy, 0);
        chk("k0_clr", pu_clear, 0);
        step();
        chk("k0_err_gone", err, 0);
        chk("k0_busy_after", busy, 0);

        // Oversized k clamps to K_MAX, done at 16+8+2 = 26.
        run_trace(31, 16);
        // Maximal k exactly.
        run_trace(16, 16);

        // Holds: during CLEAR (ignored), cycles 3-4 in FEED, cycle 13 in
        // DRAIN, cycle 16 in DONE (ignored). done lands in cycle 16.
        start = 1'b1;
        k_len = 5'd3;
        step();
        start = 1'b0;
        for (int t = 1; t <= 17; t++) begin
            case (t)
                3:       e_lane = 4'b0001;
                6:       e_lane = 4'b0011;
                7:       e_lane = 4'b0111;
                8:       e_lane = 4'b1110;
                9:       e_lane = 4'b1100;
                10:      e_lane = 4'b1000;
                default: e_lane = 0;
            endcase
            case (t)
                11:      e_row = 0;
                12:      e_row = 1;
                13, 14:  e_row = 2;
                default: e_row = 3;
            endcase
            e_addr = (t == 2) ? 0 : (t <= 5) ? 1 : 2;
            chk($sformatf("hold_busy_c%0d", t), busy, int'(t <= 16));
            chk($sformatf("hold_clr_c%0d", t), pu_clear, int'(t == 1));
            chk($sformatf("hold_pu_en_c%0d", t), pu_en, int'(t == 2 || t == 3 || (t >= 6 && t <= 10)));
            chk($sformatf("hold_rd_en_c%0d", t), rd_en, int'(t == 2 || t == 3 || t == 6));
            if (t >= 2) chk($sformatf("hold_addr_c%0d", t), rd_addr, e_addr);
            chk($sformatf("hold_lane_c%0d", t), lane_valid, e_lane);
            chk($sformatf("hold_ov_c%0d", t), out_valid, int'(t == 11 || t == 12 || t == 13 || t == 15));
            if (t >= 11) chk($sformatf("hold_row_c%0d", t), out_row, e_row);
            chk($sformatf("hold_done_c%0d", t), done, int'(t == 16));
            hold = (t == 1 || t == 3 || t == 4 || t == 13 || t == 16);
            step();
        end
        hold = 1'b0;

        // Starts while busy (FEED c=2, DONE) are ignored; k_len changes
        // after the start have no effect.
        start = 1'b1;
        k_len = 5'd3;
        step();
        start = 1'b0;
        k_len = 5'd7;
        for (int t = 1; t <= 13; t++) begin
            chk($sformatf("busy_st_err_c%0d", t), err, 0);
            chk($sformatf("busy_st_done_c%0d", t), done, int'(t == 13));
            start = (t == 4 || t == 13);
            step();
        end
        chk("b2b_idle_busy", busy, 0);
        chk("b2b_idle_err", err, 0);
        chk("b2b_idle_clr", pu_clear, 0);
        start = 1'b1;
        k_len = 5'd2;
        step();
        start = 1'b0;
        chk("b2b_clr", pu_clear, 1);
        chk("b2b_busy", busy, 1);
        for (int t = 16; t <= 27; t++) begin
            step();
            chk($sformatf("b2b_done_c%0d", t), done, int'(t == 26));
        end

        // Reset mid-FEED at c=2, then a full clean tile.
        start = 1'b1;
        k_len = 5'd3;
        step();
        start = 1'b0;
        step();
        step();
        step();
        chk("rstmid_pu_en_c4", pu_en, 1);
        chk("rstmid_addr_c4", rd_addr, 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_vals("rstmid_c5");
        step();
        chk("rstmid_done_c6", done, 0);
        chk("rstmid_busy_c6", busy, 0);
        run_trace(1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
